// File: rtl/store_buffer.sv
// ============================================================================
//  Module      : store_buffer
//  Description : Word-granular posted-write buffer with load forwarding in
//                front of a single-port data memory. Optional store
//                coalescing is enabled by defining STBUF_COALESCE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_we,
    input  logic             cpu_re,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_wd,
    output logic [31:0]      cpu_rd,
    output logic             stall,
    output logic             mem_we,
    output logic [31:0]      mem_a,
    output logic [31:0]      mem_wd,
    input  logic [31:0]      mem_rd,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int               PTR_W  = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    logic [29:0]      r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic [29:0]      w_word;
    logic             w_full;
    logic             w_nonempty;
    logic             w_pop;
    logic             w_push;
    logic             w_coal;
    logic             w_hit;
    logic [31:0]      w_hit_data;
    logic [PTR_W-1:0] w_slot_idx [DEPTH];
    logic             w_slot_vld [DEPTH];
    logic             w_unused_lsb;

    assign w_word       = cpu_addr[31:2];
    assign w_unused_lsb = &{1'b0, cpu_addr[1:0]};
    assign w_full       = (r_count == C_FULL);
    assign w_nonempty   = (r_count != '0);
    // Loads own the port; drain only on cycles without a load.
    assign w_pop        = reset & ~cpu_re & w_nonempty;

    // Slot i is the i-th oldest buffered entry counted from the head.
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_slot
            assign w_slot_idx[i] = r_head + PTR_W'(i);
            assign w_slot_vld[i] = (CNT_W'(i) < r_count);
        end
    endgenerate

`ifdef STBUF_COALESCE_EN
    logic [PTR_W-1:0] w_hit_idx;
`endif

    // Oldest-to-youngest scan: the last match found is the youngest.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_data = '0;
`ifdef STBUF_COALESCE_EN
        w_hit_idx  = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            if (w_slot_vld[i] && (r_addr[w_slot_idx[i]] == w_word)) begin
                w_hit      = 1'b1;
                w_hit_data = r_data[w_slot_idx[i]];
`ifdef STBUF_COALESCE_EN
                w_hit_idx  = w_slot_idx[i];
`endif
            end
        end
    end

`ifdef STBUF_COALESCE_EN
    // A match on the head that leaves this cycle cannot absorb the store.
    assign w_coal = reset & cpu_we & w_hit & ~(w_pop && (w_hit_idx == r_head));
`else
    assign w_coal = 1'b0;
`endif

    assign w_push = reset & cpu_we & ~w_full & ~w_coal;
    assign stall  = reset & cpu_we & w_full & ~w_coal;

    assign cpu_rd = !reset ? 32'd0 : (w_hit ? w_hit_data : mem_rd);
    assign mem_we = w_pop;

    always_comb begin
        mem_a  = 32'd0;
        mem_wd = 32'd0;
        if (cpu_re) begin
            mem_a = {w_word, 2'b00};
        end else if (w_nonempty) begin
            mem_a  = {r_addr[r_head], 2'b00};
            mem_wd = r_data[r_head];
        end
    end

    assign empty = (r_count == '0);
    assign count = r_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Entry storage needs no reset; validity is carried by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= w_word;
            r_data[r_tail] <= cpu_wd;
        end
`ifdef STBUF_COALESCE_EN
        else if (w_coal) begin
            r_data[w_hit_idx] <= cpu_wd;
        end
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// ============================================================================
//  Module      : tb_store_buffer
//  Description : Scoreboard bench for store_buffer; expected memory writes are
//                queued at stimulus time and checked by a drain monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_we;
    logic        cpu_re;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wd;
    logic [31:0] cpu_rd;
    logic        stall;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic        empty;
    logic [2:0]  count;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q[$];

    logic [31:0] mem [0:255];

    store_buffer #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset), .cpu_we(cpu_we), .cpu_re(cpu_re),
        .cpu_addr(cpu_addr), .cpu_wd(cpu_wd), .cpu_rd(cpu_rd), .stall(stall),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[9:2]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_a[9:2]] <= mem_wd;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drain monitor: every memory write must match the oldest expected one.
    always @(negedge clk) begin
        if (reset === 1'b1 && mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected none", mem_a, mem_wd);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("drain_addr", mem_a, e.a);
                chk("drain_data", mem_wd, e.d);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
        cpu_we   = we;
        cpu_re   = re;
        cpu_addr = a;
        cpu_wd   = d;
        #1;
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_empty();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 20; i++) begin
            if (empty) break;
            step();
        end
        chk("drain_done_empty", {31'd0, empty}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
        mem[32'h80 >> 2] = 32'h0;

        // Reset held with a store request present
        reset = 1'b0;
        drive(1'b1, 1'b0, 32'h100, 32'h1);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("rst_count", {29'd0, count}, 32'd0);
            chk("rst_empty", {31'd0, empty}, 32'd1);
            chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
            chk("rst_stall", {31'd0, stall}, 32'd0);
            chk("rst_cpu_rd", cpu_rd, 32'd0);
        end
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        chk("post_rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("post_rst_count", {29'd0, count}, 32'd0);

        // Single store then idle
        drive(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF);
        expect_wr(32'h10, 32'hDEAD_BEEF);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        chk("single_mem_we", {31'd0, mem_we}, 32'd1);
        chk("single_mem_a", mem_a, 32'h10);
        step();
        chk("single_count", {29'd0, count}, 32'd0);
        chk("single_empty", {31'd0, empty}, 32'd1);

        // Fill under sustained loads, then stall on the fifth store
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 32'(k * 4), 32'hA0 + 32'(k));
            chk("fill_stall", {31'd0, stall}, 32'd0);
            expect_wr(32'(k * 4), 32'hA0 + 32'(k));
            step();
        end
        chk("fill_count", {29'd0, count}, 32'd4);
        drive(1'b1, 1'b1, 32'h20, 32'hB0);
        chk("full_stall_load", {31'd0, stall}, 32'd1);
        chk("full_no_drain", {31'd0, mem_we}, 32'd0);
        step();
        chk("full_count_hold", {29'd0, count}, 32'd4);
        drive(1'b1, 1'b0, 32'h20, 32'hB0);
        chk("full_stall_drain", {31'd0, stall}, 32'd1);
        step();
        chk("after_drain_count", {29'd0, count}, 32'd3);
        chk("retry_stall", {31'd0, stall}, 32'd0);
        expect_wr(32'h20, 32'hB0);
        step();
        chk("retry_count", {29'd0, count}, 32'd3);
        wait_empty();

        // Forwarding picks the youngest match
        drive(1'b1, 1'b1, 32'h40, 32'h11);
        step();
        drive(1'b1, 1'b1, 32'h40, 32'h22);
        step();
`ifdef STBUF_COALESCE_EN
        expect_wr(32'h40, 32'h22);
        chk("coal_fwd_count", {29'd0, count}, 32'd1);
`else
        expect_wr(32'h40, 32'h11);
        expect_wr(32'h40, 32'h22);
        chk("fwd_count", {29'd0, count}, 32'd2);
`endif
        drive(1'b0, 1'b1, 32'h40, 32'h0);
        chk("fwd_youngest", cpu_rd, 32'h22);
        drive(1'b0, 1'b1, 32'h44, 32'h0);
        chk("fwd_miss", cpu_rd, 32'hA500_0011);
        wait_empty();
        chk("fwd_mem_final", mem[32'h40 >> 2], 32'h22);

        // Same-cycle store and load do not forward to each other
        drive(1'b1, 1'b1, 32'h80, 32'h55);
        chk("simul_rd", cpu_rd, 32'h0);
        expect_wr(32'h80, 32'h55);
        step();
        chk("simul_count", {29'd0, count}, 32'd1);
        drive(1'b0, 1'b1, 32'h80, 32'h0);
        chk("simul_next_rd", cpu_rd, 32'h55);
        wait_empty();

        // Full buffer with a matching entry
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 32'(k * 4), 32'(k + 1));
            step();
        end
        drive(1'b1, 1'b1, 32'h8, 32'h99);
`ifdef STBUF_COALESCE_EN
        chk("coal_stall", {31'd0, stall}, 32'd0);
        step();
        chk("coal_count", {29'd0, count}, 32'd4);
        expect_wr(32'h0, 32'h1);
        expect_wr(32'h4, 32'h2);
        expect_wr(32'h8, 32'h99);
        expect_wr(32'hC, 32'h4);
`else
        chk("nocoal_stall", {31'd0, stall}, 32'd1);
        step();
        chk("nocoal_count", {29'd0, count}, 32'd4);
        expect_wr(32'h0, 32'h1);
        expect_wr(32'h4, 32'h2);
        expect_wr(32'h8, 32'h3);
        expect_wr(32'hC, 32'h4);
`endif
        wait_empty();

        // Buffered stores are discarded by reset
        drive(1'b1, 1'b1, 32'h30, 32'h77);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        #1;
        chk("discard_count", {29'd0, count}, 32'd0);
        chk("discard_mem_we", {31'd0, mem_we}, 32'd0);
        for (int k = 0; k < 3; k++) step();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Word-granular posted-write buffer between the core's load/store path and the single-port word data memory (combinational read, synchronous write).
- Stores are accepted into a small FIFO at once and drained to memory on cycles with no load using the port.
- Loads get read-after-write forwarding from buffered stores.
- The core stalls only when a store arrives with the buffer full.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, minimum 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low; sampled on the rising edge of clk.
- cpu_we  in  1  store request.
- cpu_re  in  1  load request.
- cpu_addr  in  32  byte address; bits [1:0] ignored.
- cpu_wd  in  32  store data.
- cpu_rd  out  32  load data, combinational.
- stall  out  1  store not accepted this cycle; core holds its request.
- mem_we  out  1  write enable to data memory.
- mem_a  out  32  address to data memory.
- mem_wd  out  32  write data to data memory.
- mem_rd  in  32  read data from data memory.
- empty  out  1  buffer holds no stores.
- count  out  CNT_W  number of buffered stores.

Behaviour:
- Storage: DEPTH entries of {word address [31:2], data [31:0]}, circular head/tail pointers, occupancy count.
- Reset (reset=0 at a clk edge): head=tail=count=0. Buffered stores are discarded, not drained.
- While reset=0: mem_we=0, stall=0, cpu_rd=0, empty=1, count=0. mem_a and mem_wd are don't-care with mem_we=0.
- Port arbitration, combinational each cycle:
  - cpu_re=1: mem_a={cpu_addr[31:2],2'b00}, mem_we=0. No drain this cycle; loads have priority.
  - Otherwise, if count>0: mem_we=1, mem_a={head.addr,2'b00}, mem_wd=head.data. Head pops at the edge (drain latency 0 once the port is free).
  - Otherwise: mem_we=0, mem_a=0, mem_wd=0.
- Store acceptance:
  - cpu_we=1 and count<DEPTH: push at tail on the edge; stall=0.
  - cpu_we=1 and count==DEPTH: stall=1, no push. This holds even if a drain occurs the same cycle. The store is accepted the next cycle.
  - stall is combinational: cpu_we & full & reset.
- Push and pop on the same edge: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Load forwarding: cpu_rd = data of the youngest buffered entry whose addr equals cpu_addr[31:2], else mem_rd.
  - Youngest means the nearest to tail, scanning backward.
  - An entry popping this cycle still forwards, since it is still valid during the cycle.
- cpu_we and cpu_re both 1: load uses the port, no drain, and the store pushes if not full. The load does NOT see the same-cycle store data.
- Sustained loads never drain the buffer. Draining resumes on the first cycle with cpu_re=0.
- empty = (count==0). count is registered.
- Ordering: stores reach memory in acceptance order. No store is lost except on reset.

Optional Feature:
- Macro: STBUF_COALESCE_EN.
- Defined: a store whose word address matches a buffered entry overwrites the data of the youngest matching entry in place.
  - No push and no count change.
  - Accepted even when full (stall=0).
  - Exception: if the youngest match is the head popping this cycle, the store pushes normally, or stalls if full.
- Not defined: every accepted store occupies a new entry. No address comparison on the store path.

Test Plan:
- Reset: hold reset=0 two cycles with cpu_we=1 -> count=0, empty=1, mem_we=0, stall=0. Release with buffer contents discarded -> no write reaches memory.
- Single store then idle: store 0x10/0xDEADBEEF -> next cycle mem_we=1, mem_a=0x10, mem_wd=0xDEADBEEF. Following cycle count=0, empty=1.
- Fill and stall: cpu_re=1 held while storing 0x0,0x4,0x8,0xC -> count=4. Fifth store 0x20 -> stall=1 until a cpu_re=0 cycle; drains in order 0x0,0x4,0x8,0xC,0x20.
- Forwarding: with 0x40/0x11 then 0x40/0x22 buffered and loads held -> load 0x40 returns 0x22; load 0x44 returns mem_rd. After drain, memory word 0x40 = 0x22.
- Simultaneous: cpu_we=1 0x80/0x55 and cpu_re=1 0x80 in the same cycle, mem_rd=0 -> cpu_rd=0, count increments. Next-cycle load 0x80 -> 0x55.
- Coalesce (macro defined): buffer full with a match at 0x8, store 0x8/0x99 -> stall=0, count stays 4, drains 0x99 at 0x8. Without the macro -> stall=1.
